// File: rtl/ct_ifu_rst_inv_seq_if.sv
// ---------------------------------------------------------------------------
// ct_ifu_rst_inv_seq_if
// Bundles the reset-invalidate sequencer's request, per-array enables, the
// three invalidate write handshakes, the completion level and the debug
// state view.
//   master : the sequencer (drives vld/idx/done/debug, samples req/en/rdy)
//   slave  : the vector unit / arrays side (drives req/en/rdy)
// ---------------------------------------------------------------------------
interface ct_ifu_rst_inv_seq_if #(
  parameter int ICACHE_IDX_W = 8,
  parameter int BHT_IDX_W    = 10,
  parameter int BTB_IDX_W    = 6
);
  logic                    ifu_cp0_rst_inv_req;
  logic                    cp0_inv_icache_en;
  logic                    cp0_inv_bht_en;
  logic                    cp0_inv_btb_en;

  logic                    seq_icache_inv_vld;
  logic [ICACHE_IDX_W-1:0] seq_icache_inv_idx;
  logic                    icache_seq_inv_rdy;

  logic                    seq_bht_inv_vld;
  logic [BHT_IDX_W-1:0]    seq_bht_inv_idx;
  logic                    bht_seq_inv_rdy;

  logic                    seq_btb_inv_vld;
  logic [BTB_IDX_W-1:0]    seq_btb_inv_idx;
  logic                    btb_seq_inv_rdy;

  logic                    cp0_ifu_rst_inv_done;
  logic [4:0]              seq_debug_cur_st;

  modport master (
    input  ifu_cp0_rst_inv_req, cp0_inv_icache_en, cp0_inv_bht_en, cp0_inv_btb_en,
    input  icache_seq_inv_rdy, bht_seq_inv_rdy, btb_seq_inv_rdy,
    output seq_icache_inv_vld, seq_icache_inv_idx,
    output seq_bht_inv_vld, seq_bht_inv_idx,
    output seq_btb_inv_vld, seq_btb_inv_idx,
    output cp0_ifu_rst_inv_done, seq_debug_cur_st
  );

  modport slave (
    output ifu_cp0_rst_inv_req, cp0_inv_icache_en, cp0_inv_bht_en, cp0_inv_btb_en,
    output icache_seq_inv_rdy, bht_seq_inv_rdy, btb_seq_inv_rdy,
    input  seq_icache_inv_vld, seq_icache_inv_idx,
    input  seq_bht_inv_vld, seq_bht_inv_idx,
    input  seq_btb_inv_vld, seq_btb_inv_idx,
    input  cp0_ifu_rst_inv_done, seq_debug_cur_st
  );
endinterface

// File: rtl/ct_ifu_rst_inv_seq.sv
// ---------------------------------------------------------------------------
// ct_ifu_rst_inv_seq
// Reset-invalidate sequencer ahead of the IFU vector state machine. A one
// cycle request walks every index of the enabled arrays (I-cache tag, BHT,
// L0 BTB, in that order), one invalidate write per index under valid/ready,
// then raises a completion level that holds until the next request.
// Ports:
//   vec_sm_clk : clock
//   cpurst_b   : asynchronous active-low reset
//   bus        : ct_ifu_rst_inv_seq_if.master (request, enables, three
//                invalidate handshakes, done level, one-hot debug state)
// All outputs decode registered state only; rdy/req never reach vld/done
// combinationally.
// ---------------------------------------------------------------------------
module ct_ifu_rst_inv_seq #(
  parameter int ICACHE_IDX_W = 8,
  parameter int BHT_IDX_W    = 10,
  parameter int BTB_IDX_W    = 6
) (
  input  logic                        vec_sm_clk,
  input  logic                        cpurst_b,
  ct_ifu_rst_inv_seq_if.master        bus
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    ICACHE = 5'b00010,
    BHT    = 5'b00100,
    BTB    = 5'b01000,
    DONE   = 5'b10000
  } state_e;

  typedef struct packed {
    logic btb;
    logic bht;
    logic icache;
  } inv_en_t;

  // The counter is shared by all phases and sized for the widest array (BHT).
  localparam int            CNT_W   = BHT_IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             cur_st, nxt_st;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  inv_en_t            en_q, en_nxt;
  inv_en_t            en_req;

  assign en_req = '{btb: bus.cp0_inv_btb_en, bht: bus.cp0_inv_bht_en,
                    icache: bus.cp0_inv_icache_en};

  // Phase-terminal index: the last index of each array. Upper counter bits
  // stay zero in narrower phases because the counter is cleared on exit.
  logic icache_last, bht_last, btb_last;
  assign icache_last = (cnt_q[ICACHE_IDX_W-1:0] == {ICACHE_IDX_W{1'b1}});
  assign bht_last    = (cnt_q[BHT_IDX_W-1:0]    == {BHT_IDX_W{1'b1}});
  assign btb_last    = (cnt_q[BTB_IDX_W-1:0]    == {BTB_IDX_W{1'b1}});

  // -------------------------------------------------------------------------
  // State register (plus the counter and latched enables it owns)
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge vec_sm_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cur_st <= IDLE;
      cnt_q  <= '0;
      en_q   <= '0;
    end else begin
      cur_st <= nxt_st;
      cnt_q  <= cnt_nxt;
      en_q   <= en_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here is defaulted first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    nxt_st  = cur_st;
    cnt_nxt = cnt_q;
    en_nxt  = en_q;
    case (cur_st)
      IDLE, DONE: begin
        if (bus.ifu_cp0_rst_inv_req) begin
          en_nxt  = en_req;
          cnt_nxt = '0;
          if (en_req.icache)   nxt_st = ICACHE;
          else if (en_req.bht) nxt_st = BHT;
          else if (en_req.btb) nxt_st = BTB;
          else                 nxt_st = DONE;
        end
      end
      // vld is constant 1 inside a phase, so the handshake is just rdy.
      ICACHE: begin
        if (bus.icache_seq_inv_rdy) begin
          if (icache_last) begin
            cnt_nxt = '0;
            if (en_q.bht)      nxt_st = BHT;
            else if (en_q.btb) nxt_st = BTB;
            else               nxt_st = DONE;
          end else begin
            cnt_nxt = cnt_q + CNT_ONE;
          end
        end
      end
      BHT: begin
        if (bus.bht_seq_inv_rdy) begin
          if (bht_last) begin
            cnt_nxt = '0;
            nxt_st  = en_q.btb ? BTB : DONE;
          end else begin
            cnt_nxt = cnt_q + CNT_ONE;
          end
        end
      end
      BTB: begin
        if (bus.btb_seq_inv_rdy) begin
          if (btb_last) begin
            cnt_nxt = '0;
            nxt_st  = DONE;
          end else begin
            cnt_nxt = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        nxt_st  = IDLE;
        cnt_nxt = '0;
        en_nxt  = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode (registered state only)
  // -------------------------------------------------------------------------
  always_comb begin
    bus.seq_icache_inv_vld   = (cur_st == ICACHE);
    bus.seq_bht_inv_vld      = (cur_st == BHT);
    bus.seq_btb_inv_vld      = (cur_st == BTB);
    bus.cp0_ifu_rst_inv_done = (cur_st == DONE);
    bus.seq_debug_cur_st     = cur_st;
    // Idle arrays see index 0 rather than another phase's counter bits.
    bus.seq_icache_inv_idx   = '0;
    bus.seq_bht_inv_idx      = '0;
    bus.seq_btb_inv_idx      = '0;
    if (cur_st == ICACHE) bus.seq_icache_inv_idx = cnt_q[ICACHE_IDX_W-1:0];
    if (cur_st == BHT)    bus.seq_bht_inv_idx    = cnt_q[BHT_IDX_W-1:0];
    if (cur_st == BTB)    bus.seq_btb_inv_idx    = cnt_q[BTB_IDX_W-1:0];
  end

endmodule

// File: tb/tb_ct_ifu_rst_inv_seq.sv
// ---------------------------------------------------------------------------
// tb_ct_ifu_rst_inv_seq
// Directed bench for the reset-invalidate sequencer. Outputs are sampled on
// the falling edge; "cycle k" is the k-th falling edge after the rising edge
// that accepted the request.
// ---------------------------------------------------------------------------
module tb_ct_ifu_rst_inv_seq;

  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_ICACHE = 5'b00010;
  localparam logic [4:0] ST_BHT    = 5'b00100;
  localparam logic [4:0] ST_BTB    = 5'b01000;
  localparam logic [4:0] ST_DONE   = 5'b10000;

  logic vec_sm_clk = 1'b0;
  logic cpurst_b   = 1'b0;
  always #5 vec_sm_clk = ~vec_sm_clk;

  int tests_run = 0;
  int tests_failed = 0;

  ct_ifu_rst_inv_seq_if bus ();

  ct_ifu_rst_inv_seq dut (
    .vec_sm_clk (vec_sm_clk),
    .cpurst_b   (cpurst_b),
    .bus        (bus)
  );

  // True when every output matches the expected state and active index.
  function automatic bit cycle_ok(input logic [4:0] st, input int idx);
    bit ok;
    logic [9:0] ix;
    ix = idx[9:0];
    ok = 1'b1;
    if (bus.seq_debug_cur_st !== st)                      ok = 1'b0;
    if (bus.seq_icache_inv_vld !== (st == ST_ICACHE))     ok = 1'b0;
    if (bus.seq_bht_inv_vld    !== (st == ST_BHT))        ok = 1'b0;
    if (bus.seq_btb_inv_vld    !== (st == ST_BTB))        ok = 1'b0;
    if (bus.cp0_ifu_rst_inv_done !== (st == ST_DONE))     ok = 1'b0;
    if (st == ST_ICACHE && bus.seq_icache_inv_idx !== ix[7:0]) ok = 1'b0;
    if (st == ST_BHT    && bus.seq_bht_inv_idx    !== ix[9:0]) ok = 1'b0;
    if (st == ST_BTB    && bus.seq_btb_inv_idx    !== ix[5:0]) ok = 1'b0;
    return ok;
  endfunction

  // Pulse req for one rising edge; returns at cycle 1.
  task automatic start_req(input logic [2:0] en);
    @(negedge vec_sm_clk);
    bus.cp0_inv_icache_en   = en[0];
    bus.cp0_inv_bht_en      = en[1];
    bus.cp0_inv_btb_en      = en[2];
    bus.ifu_cp0_rst_inv_req = 1'b1;
    @(negedge vec_sm_clk);
    bus.ifu_cp0_rst_inv_req = 1'b0;
  endtask

  // Walks the expected all-rdy sequence from cycle 1. Optionally pulses req
  // at cycle req_at, and stops (unchecked) on reaching cycle stop_at.
  // Without a stop it returns at the cycle where DONE is expected.
  task automatic walk(input logic [2:0] en, input int req_at, input int stop_at,
                      output int bad, output int first_bad);
    int c;
    int len [3];
    logic [4:0] ph [3];
    len = '{256, 1024, 64};
    ph  = '{ST_ICACHE, ST_BHT, ST_BTB};
    c = 1;
    bad = 0;
    first_bad = -1;
    for (int p = 0; p < 3; p++) begin
      if (en[p]) begin
        for (int i = 0; i < len[p]; i++) begin
          if (stop_at > 0 && c >= stop_at) return;
          if (!cycle_ok(ph[p], i)) begin
            bad++;
            if (first_bad < 0) first_bad = c;
          end
          if (c == req_at) bus.ifu_cp0_rst_inv_req = 1'b1;
          @(negedge vec_sm_clk);
          bus.ifu_cp0_rst_inv_req = 1'b0;
          c++;
        end
      end
    end
  endtask

  task automatic test_reset;
    bus.ifu_cp0_rst_inv_req = 1'b0;
    bus.cp0_inv_icache_en   = 1'b0;
    bus.cp0_inv_bht_en      = 1'b0;
    bus.cp0_inv_btb_en      = 1'b0;
    bus.icache_seq_inv_rdy  = 1'b1;
    bus.bht_seq_inv_rdy     = 1'b1;
    bus.btb_seq_inv_rdy     = 1'b1;
    cpurst_b = 1'b0;
    repeat (2) @(negedge vec_sm_clk);
    tests_run++;
    if (bus.seq_debug_cur_st !== ST_IDLE || bus.cp0_ifu_rst_inv_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: st=%b done=%b, need st=%b done=0",
               bus.seq_debug_cur_st, bus.cp0_ifu_rst_inv_done, ST_IDLE);
    end
    tests_run++;
    if ({bus.seq_icache_inv_vld, bus.seq_bht_inv_vld, bus.seq_btb_inv_vld} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_vld: vld=%b, need 000",
               {bus.seq_icache_inv_vld, bus.seq_bht_inv_vld, bus.seq_btb_inv_vld});
    end
    tests_run++;
    if (bus.seq_icache_inv_idx !== 8'd0 || bus.seq_bht_inv_idx !== 10'd0 ||
        bus.seq_btb_inv_idx !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_idx: idx=%0d/%0d/%0d, need 0/0/0", bus.seq_icache_inv_idx,
               bus.seq_bht_inv_idx, bus.seq_btb_inv_idx);
    end
    cpurst_b = 1'b1;
    repeat (2) @(negedge vec_sm_clk);
    tests_run++;
    if (!cycle_ok(ST_IDLE, 0)) begin
      tests_failed++;
      $display("FAIL idle_after_reset: st=%b, need %b", bus.seq_debug_cur_st, ST_IDLE);
    end
  endtask

  task automatic test_full_walk;
    int bad, fb, hold_bad;
    start_req(3'b111);
    walk(3'b111, -1, 0, bad, fb);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL full_walk: %0d bad cycles (first at T+%0d), need 0", bad, fb);
    end
    hold_bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (!cycle_ok(ST_DONE, 0)) hold_bad++;
      @(negedge vec_sm_clk);
    end
    tests_run++;
    if (hold_bad !== 0) begin
      tests_failed++;
      $display("FAIL full_done_hold: %0d cycles not DONE from T+1345, need 0", hold_bad);
    end
  endtask

  task automatic test_bht_only;
    int bad, fb;
    start_req(3'b010);
    walk(3'b010, -1, 0, bad, fb);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL bht_only_walk: %0d bad cycles (first at T+%0d), need 0", bad, fb);
    end
    tests_run++;
    if (!cycle_ok(ST_DONE, 0)) begin
      tests_failed++;
      $display("FAIL bht_only_done: st=%b done=%b at T+1025, need st=%b done=1",
               bus.seq_debug_cur_st, bus.cp0_ifu_rst_inv_done, ST_DONE);
    end
  endtask

  task automatic test_bht_stall;
    int e, cyc, bad, fb, dup;
    int written [1024];
    bit r;
    foreach (written[i]) written[i] = 0;
    bus.bht_seq_inv_rdy = 1'b0;
    start_req(3'b010);
    e = 0; cyc = 0; bad = 0; fb = -1;
    while (e < 1024 && cyc < 8000) begin
      if (!cycle_ok(ST_BHT, e)) begin
        bad++;
        if (fb < 0) fb = cyc + 1;
      end
      r = 1'($urandom_range(0, 1));
      bus.bht_seq_inv_rdy = r;
      if (r) written[bus.seq_bht_inv_idx]++;
      @(negedge vec_sm_clk);
      if (r) e++;
      cyc++;
    end
    tests_run++;
    if (e !== 1024) begin
      tests_failed++;
      $display("FAIL bht_stall_timeout: %0d handshakes in %0d cycles, need 1024", e, cyc);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL bht_stall_hold: %0d bad cycles (first at T+%0d), need 0", bad, fb);
    end
    dup = 0;
    foreach (written[i]) if (written[i] != 1) dup++;
    tests_run++;
    if (dup !== 0) begin
      tests_failed++;
      $display("FAIL bht_stall_once: %0d indices not written exactly once, need 0", dup);
    end
    tests_run++;
    if (!cycle_ok(ST_DONE, 0)) begin
      tests_failed++;
      $display("FAIL bht_stall_done: st=%b done=%b after last handshake, need st=%b done=1",
               bus.seq_debug_cur_st, bus.cp0_ifu_rst_inv_done, ST_DONE);
    end
    bus.bht_seq_inv_rdy = 1'b1;
  endtask

  task automatic test_req_ignored_and_restart;
    int bad, fb;
    start_req(3'b111);
    // idx 100 is on the I-cache bus at cycle 101.
    walk(3'b111, 101, 0, bad, fb);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL req_mid_ignored: %0d bad cycles (first at T+%0d), need 0", bad, fb);
    end
    tests_run++;
    if (!cycle_ok(ST_DONE, 0)) begin
      tests_failed++;
      $display("FAIL req_mid_done: st=%b, need %b", bus.seq_debug_cur_st, ST_DONE);
    end
    start_req(3'b111);
    tests_run++;
    if (bus.cp0_ifu_rst_inv_done !== 1'b0 || !cycle_ok(ST_ICACHE, 0)) begin
      tests_failed++;
      $display("FAIL restart_from_done: st=%b done=%b idx=%0d, need st=%b done=0 idx=0",
               bus.seq_debug_cur_st, bus.cp0_ifu_rst_inv_done, bus.seq_icache_inv_idx,
               ST_ICACHE);
    end
    walk(3'b111, -1, 0, bad, fb);
    tests_run++;
    if (bad !== 0 || !cycle_ok(ST_DONE, 0)) begin
      tests_failed++;
      $display("FAIL restart_walk: %0d bad cycles (first at T+%0d) st=%b, need 0 and DONE",
               bad, fb, bus.seq_debug_cur_st);
    end
  endtask

  task automatic test_reset_mid;
    int bad, fb;
    start_req(3'b111);
    // btb idx 10 is presented at cycle 1281 + 10.
    walk(3'b111, -1, 1291, bad, fb);
    tests_run++;
    if (bad !== 0 || bus.seq_btb_inv_vld !== 1'b1 || bus.seq_btb_inv_idx !== 6'd10) begin
      tests_failed++;
      $display("FAIL pre_reset_btb10: bad=%0d vld=%b idx=%0d, need 0/1/10",
               bad, bus.seq_btb_inv_vld, bus.seq_btb_inv_idx);
    end
    cpurst_b = 1'b0;
    #1;
    tests_run++;
    if (!cycle_ok(ST_IDLE, 0)) begin
      tests_failed++;
      $display("FAIL reset_mid_async: st=%b vld=%b done=%b, need st=%b vld=000 done=0",
               bus.seq_debug_cur_st,
               {bus.seq_icache_inv_vld, bus.seq_bht_inv_vld, bus.seq_btb_inv_vld},
               bus.cp0_ifu_rst_inv_done, ST_IDLE);
    end
    @(negedge vec_sm_clk);
    cpurst_b = 1'b1;
    start_req(3'b111);
    tests_run++;
    if (!cycle_ok(ST_ICACHE, 0)) begin
      tests_failed++;
      $display("FAIL reset_mid_restart: st=%b idx=%0d, need st=%b idx=0",
               bus.seq_debug_cur_st, bus.seq_icache_inv_idx, ST_ICACHE);
    end
    walk(3'b111, -1, 0, bad, fb);
    tests_run++;
    if (bad !== 0 || !cycle_ok(ST_DONE, 0)) begin
      tests_failed++;
      $display("FAIL reset_mid_rewalk: %0d bad cycles (first at T+%0d), need 0 and DONE",
               bad, fb);
    end
  endtask

  task automatic test_no_enable;
    int bad;
    start_req(3'b000);
    tests_run++;
    if (!cycle_ok(ST_DONE, 0)) begin
      tests_failed++;
      $display("FAIL no_en_done: st=%b done=%b at T+1, need st=%b done=1",
               bus.seq_debug_cur_st, bus.cp0_ifu_rst_inv_done, ST_DONE);
    end
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge vec_sm_clk);
      if (!cycle_ok(ST_DONE, 0)) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL no_en_quiet: %0d cycles with vld or not done, need 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_full_walk();
    test_bht_only();
    test_bht_stall();
    test_req_ignored_and_restart();
    test_reset_mid();
    test_no_enable();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit, need completion");
    $fatal(1, "timeout");
  end

endmodule
